// File: rtl/tdm_demux_pkg.sv
// ============================================================================
//  Package : tdm_demux_pkg
//  Brief   : Shared frame-format definitions for the TDM link (state
//            encoding, default frame geometry, counter sizing helper).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

    // Receiver lock state: hunting for fsync, or receiving locked frames.
    typedef enum logic {
        S_HUNT = 1'b0,
        S_RECV = 1'b1
    } tdm_state_e;

    // Default frame format, shared with the transmit side.
    localparam int unsigned DEF_N_CH = 4;
    localparam int unsigned DEF_W    = 8;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_slot_shifter.sv
// ============================================================================
//  Module  : tdm_slot_shifter
//  Brief   : W-bit MSB-first shift register with enable and clear. The
//            newest bit lands in bit 0, so after W shifts the first bit
//            received sits in the MSB.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_slot_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,     // shift one bit in
    input  logic         clr_i,    // with en_i: restart the word from bit_i
    input  logic         bit_i,
    output logic [W-1:0] word_o
);

    logic [W-1:0] shift_q;

    // Shift on enable; a clear discards the partial word so bit_i starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                shift_q <= {{(W-1){1'b0}}, bit_i};
            end else begin
                shift_q <= {shift_q[W-2:0], bit_i};
            end
        end
    end

    assign word_o = shift_q;

endmodule

`default_nettype wire

// File: rtl/tdm_demux.sv
// ============================================================================
//  Module  : tdm_demux
//  Brief   : TDM receive demultiplexer. Locks to fsync, deserialises N_CH
//            slots of W bits (MSB first) per frame and presents each slot
//            on its own registered channel output with a 1-cycle valid.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned W    = DEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              sdi,
    input  logic              fsync,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              locked
);

    localparam int unsigned BW = cnt_width(W);
    localparam int unsigned CW = cnt_width(N_CH);

    localparam logic [BW-1:0] C_LAST_BIT = BW'(W - 1);
    localparam logic [CW-1:0] C_LAST_CH  = CW'(N_CH - 1);

    tdm_state_e        state_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [CW-1:0]     ch_cnt_q;
    logic [N_CH*W-1:0] ch_data_q;
    logic [N_CH-1:0]   ch_valid_q;
    logic              frame_done_q;
    logic              sync_err_q;

    logic              w_hunt;
    logic              w_frame_start;
    logic              w_misplaced;
    logic              w_missing;
    logic              w_slot_end;
    logic              w_sh_en;
    logic              w_sh_clr;
    logic [W-1:0]      w_sh_word;
    logic [W-1:0]      w_slot_word;

    assign w_hunt        = (state_q == S_HUNT);
    assign w_frame_start = (bit_cnt_q == '0) && (ch_cnt_q == '0);
    // fsync where no frame starts: drop the partial slot and restart here.
    assign w_misplaced   = !w_hunt && fsync && !w_frame_start;
    // No fsync where a frame must start: lose lock, the bit is discarded.
    assign w_missing     = !w_hunt && !fsync && w_frame_start;
    assign w_slot_end    = (bit_cnt_q == C_LAST_BIT);

    // In HUNT only the fsync bit is captured; a missing fsync captures nothing.
    assign w_sh_en  = bit_en && (w_hunt ? fsync : !w_missing);
    assign w_sh_clr = w_hunt || w_misplaced;

    tdm_slot_shifter #(
        .W (W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (w_sh_en),
        .clr_i  (w_sh_clr),
        .bit_i  (sdi),
        .word_o (w_sh_word)
    );

    // The completing bit is still on sdi, so the slot word is assembled here.
    assign w_slot_word = {w_sh_word[W-2:0], sdi};

    // Lock FSM, bit/slot counters, fsync checker and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (bit_en) begin
                unique case (state_q)
                    S_HUNT: begin
                        if (fsync) begin
                            state_q   <= S_RECV;
                            bit_cnt_q <= BW'(1);
                            ch_cnt_q  <= '0;
                        end
                    end
                    S_RECV: begin
                        if (w_misplaced) begin
                            sync_err_q <= 1'b1;
                            bit_cnt_q  <= BW'(1);
                            ch_cnt_q   <= '0;
                        end else if (w_missing) begin
                            sync_err_q <= 1'b1;
                            state_q    <= S_HUNT;
                        end else if (w_slot_end) begin
                            for (int c = 0; c < int'(N_CH); c++) begin
                                if (ch_cnt_q == CW'(c)) begin
                                    ch_data_q[c*W +: W] <= w_slot_word;
                                    ch_valid_q[c]       <= 1'b1;
                                end
                            end
                            bit_cnt_q <= '0;
                            if (ch_cnt_q == C_LAST_CH) begin
                                ch_cnt_q     <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                ch_cnt_q <= ch_cnt_q + CW'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == S_RECV);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
//  Module  : tb_tdm_demux
//  Brief   : Self-checking bench for tdm_demux: directed frame scenarios
//            plus randomized traffic against a frame-position reference.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int FBITS = N_CH * W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bit_en;
    logic              sdi;
    logic              fsync;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              frame_done;
    logic              sync_err;
    logic              locked;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock flag plus position within the frame in bits.
    bit                m_locked;
    int                m_pos;
    int                m_cur;
    logic [N_CH*W-1:0] m_data;
    logic [N_CH-1:0]   m_valid;
    bit                m_done;
    bit                m_err;

    int cnt_done;
    int cnt_err;
    int cnt_valid;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .fsync      (fsync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_cur    = 0;
        m_data   = '0;
        m_valid  = '0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock of the receiver, described by frame position rather than counters.
    task automatic model_step();
        int slot;
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (!bit_en) return;
        if (!m_locked) begin
            if (fsync) begin
                m_locked = 1'b1;
                m_pos    = 1;
                m_cur    = int'(sdi);
            end
        end else if (fsync && m_pos != 0) begin
            m_err = 1'b1;
            m_pos = 1;
            m_cur = int'(sdi);
        end else if (!fsync && m_pos == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_cur = m_cur * 2 + int'(sdi);
            m_pos = m_pos + 1;
            if (m_pos % W == 0) begin
                slot = m_pos / W - 1;
                m_data[slot*W +: W] = m_cur[W-1:0];
                m_valid[slot] = 1'b1;
                m_done = (slot == N_CH - 1);
                m_cur = 0;
                if (m_pos == FBITS) m_pos = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ch_data",    64'(ch_data),    64'(m_data));
        chk("ch_valid",   64'(ch_valid),   64'(m_valid));
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("sync_err",   64'(sync_err),   64'(m_err));
        chk("locked",     64'(locked),     64'(m_locked));
        if (frame_done) cnt_done++;
        if (sync_err)   cnt_err++;
        if (ch_valid != '0) cnt_valid++;
    endtask

    // Drive one clock of stimulus at the falling edge, check after the rising edge.
    task automatic step(input logic b, input logic fs, input logic en);
        @(negedge clk);
        sdi    = b;
        fsync  = fs;
        bit_en = en;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Send one frame MSB first; slot c taken from word[c*W +: W].
    // toggle: insert an idle (bit_en=0, noisy sdi/fsync) clock after each bit.
    task automatic send_frame(input logic [FBITS-1:0] word, input logic fs_first, input bit toggle);
        logic [W-1:0] slot;
        for (int c = 0; c < N_CH; c++) begin
            slot = word[c*W +: W];
            for (int b = W - 1; b >= 0; b--) begin
                step(slot[b], (c == 0 && b == W - 1) ? fs_first : 1'b0, 1'b1);
                if (toggle) step(1'($urandom), 1'b1, 1'b0);
            end
        end
    endtask

    task automatic clear_counts();
        cnt_done  = 0;
        cnt_err   = 0;
        cnt_valid = 0;
    endtask

    initial begin
        logic [FBITS-1:0] fw;
        int gen_pos;
        logic fs;

        rst_n  = 1'b0;
        bit_en = 1'b0;
        sdi    = 1'b0;
        fsync  = 1'b0;
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();

        // 1: reset release then a single frame
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        send_frame(32'h01FF3CA5, 1'b1, 1'b0);
        chk("s1_data",   64'(ch_data), 64'h01FF3CA5);
        chk("s1_done",   64'(cnt_done), 64'd1);
        chk("s1_locked", 64'(locked), 64'd1);

        // 2: back-to-back frame
        clear_counts();
        send_frame(32'h44332211, 1'b1, 1'b0);
        chk("s2_data",  64'(ch_data), 64'h44332211);
        chk("s2_err",   64'(cnt_err), 64'd0);
        send_frame(32'h8899AABB, 1'b1, 1'b0);
        chk("s2_done",  64'(cnt_done), 64'd2);

        // 3: fsync at bit 3 of slot 2; slot 2 is not written, new frame from there
        clear_counts();
        fw = 32'h5A6B7C8D;
        for (int b = 0; b < 2 * W + 3; b++) step(fw[FBITS-1-b], (b == 0), 1'b1);
        send_frame(32'hC3D2E1F0, 1'b1, 1'b0);
        chk("s3_err",  64'(cnt_err), 64'd1);
        chk("s3_data", 64'(ch_data), 64'hC3D2E1F0);

        // 4: fsync missing at frame start, then relock
        clear_counts();
        send_frame(32'h13579BDF, 1'b0, 1'b0);
        chk("s4_err",    64'(cnt_err), 64'd1);
        chk("s4_valid",  64'(cnt_valid), 64'd0);
        chk("s4_locked", 64'(locked), 64'd0);
        send_frame(32'h2468ACE0, 1'b1, 1'b0);
        chk("s4_data",   64'(ch_data), 64'h2468ACE0);

        // 5: bit_en toggling during the frame
        clear_counts();
        send_frame(32'h01FF3CA5, 1'b1, 1'b1);
        chk("s5_data", 64'(ch_data), 64'h01FF3CA5);
        chk("s5_done", 64'(cnt_done), 64'd1);

        // 6: asynchronous reset at bit 4 of slot 1
        fw = 32'hDEADBEEF;
        for (int b = 0; b < W + 4; b++) step(fw[b], (b == 0), 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("s6_async_data",   64'(ch_data), 64'd0);
        chk("s6_async_locked", 64'(locked), 64'd0);
        step(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int b = 0; b < 2 * FBITS; b++) step(1'($urandom), 1'b0, 1'b1);
        chk("s6_no_strobe", 64'(cnt_valid), 64'd0);

        // Randomized traffic: mostly well-placed fsync, occasional faults
        gen_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 4) == 0) begin
                step(1'($urandom), 1'($urandom), 1'b0);
            end else begin
                fs = (gen_pos % FBITS == 0);
                if (($urandom % 40) == 0) fs = ~fs;
                step(1'($urandom), fs, 1'b1);
                gen_pos++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
